// File: rtl/ann_seq_ctrl.sv
// ann_seq_ctrl: sequential evaluator for the 8-16-4 sleep-stage classifier.
// A single multiply-accumulate unit walks the network one neuron at a time.
// Weights and biases stream in from an external synchronous weight memory.
// Hidden activations acc*256/(256+|acc|) come from an 8-step restoring divider.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   start              evaluation request, honoured only in idle
//   f0..f7             signed Q8.8 features, captured on an accepted start
//   w_rd_en, w_addr    weight memory read request (data returns next cycle)
//   w_rdata            signed Q8.8 weight word
//   busy               high while an evaluation is in flight
//   done               one-cycle pulse when o0..o3/predicted_stage update
//   o0..o3             signed output scores
//   predicted_stage    argmax of o0..o3, ties to the lowest index
module ann_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] f0,
    input  logic [15:0] f1,
    input  logic [15:0] f2,
    input  logic [15:0] f3,
    input  logic [15:0] f4,
    input  logic [15:0] f5,
    input  logic [15:0] f6,
    input  logic [15:0] f7,
    output logic        w_rd_en,
    output logic [7:0]  w_addr,
    input  logic [15:0] w_rdata,
    output logic        busy,
    output logic        done,
    output logic [15:0] o0,
    output logic [15:0] o1,
    output logic [15:0] o2,
    output logic [15:0] o3,
    output logic [1:0]  predicted_stage
);

    typedef enum logic [2:0] {StIdle, StL0Mac, StL0Act, StL1Mac, StArgmax} state_e;

    state_e             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [3:0]         idx_q, idx_d;
    logic signed [15:0] feat_q [8];
    logic signed [15:0] feat_d [8];
    logic signed [15:0] hid_q [16];
    logic signed [15:0] hid_d [16];
    logic signed [31:0] acc_q, acc_d;
    logic [40:0]        rem_q, rem_d;
    logic [6:0]         quo_q, quo_d;
    logic signed [15:0] stg_q [4];
    logic signed [15:0] stg_d [4];
    logic signed [15:0] out_q [4];
    logic signed [15:0] out_d [4];
    logic [1:0]         stage_q, stage_d;
    logic               done_q, done_d;
    logic               rd_en_q, rd_en_d;
    logic [7:0]         addr_q, addr_d;

    logic signed [15:0] wsig, mul_a, best_v;
    logic signed [31:0] prod;
    logic [2:0]         l0_tap;
    logic [3:0]         l1_tap;
    logic [32:0]        acc_ext, acc_abs;
    logic [40:0]        den, rem_cur, den_sh, rem_nxt;
    logic               q_bit;
    logic [7:0]         quo_nxt;
    logic [15:0]        hid_mag, hid_val;
    logic [1:0]         best;

    // Shared datapath: MAC operand select, divider step, argmax scan.
    always_comb begin
        wsig   = w_rdata;
        // Data for the read issued at count c returns at count c+1.
        l0_tap = cnt_q[2:0] - 3'd1;
        l1_tap = cnt_q[3:0] - 4'd1;
        mul_a  = (state_q == StL0Mac) ? feat_q[l0_tap] : hid_q[l1_tap];
        prod   = 32'(mul_a) * 32'(wsig);

        acc_ext = {acc_q[31], acc_q};
        acc_abs = acc_q[31] ? (~acc_ext + 33'd1) : acc_ext;
        den     = {8'd0, acc_abs} + 41'd256;
        // Quotient is below 256, so trial subtraction starts at den<<7.
        rem_cur = (cnt_q == 5'd0) ? {acc_abs, 8'd0} : rem_q;
        den_sh  = den << (3'd7 - cnt_q[2:0]);
        q_bit   = (rem_cur >= den_sh);
        rem_nxt = q_bit ? (rem_cur - den_sh) : rem_cur;
        quo_nxt = {quo_q, q_bit};
        hid_mag = {8'd0, quo_nxt};
        hid_val = acc_q[31] ? (~hid_mag + 16'd1) : hid_mag;

        best   = 2'd0;
        best_v = stg_q[0];
        for (int k = 1; k < 4; k++) begin
            if (stg_q[k] > best_v) begin
                best   = 2'(k);
                best_v = stg_q[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        feat_d  = feat_q;
        hid_d   = hid_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        stg_d   = stg_q;
        out_d   = out_q;
        stage_d = stage_q;
        done_d  = 1'b0;
        rd_en_d = 1'b0;
        addr_d  = addr_q;

        unique case (state_q)
            StIdle: begin
                // The done cycle is still idle but must not accept a start.
                if (start && !done_q) begin
                    state_d = StL0Mac;
                    cnt_d   = 5'd0;
                    idx_d   = 4'd0;
                    feat_d  = '{f0, f1, f2, f3, f4, f5, f6, f7};
                end
            end
            StL0Mac: begin
                if (cnt_q == 5'd0)      acc_d = '0;
                else if (cnt_q <= 5'd8) acc_d = acc_q + prod;
                else                    acc_d = acc_q + (32'(wsig) <<< 8);
                if (cnt_q == 5'd9) begin
                    state_d = StL0Act;
                    cnt_d   = 5'd0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StL0Act: begin
                rem_d = rem_nxt;
                quo_d = quo_nxt[6:0];
                if (cnt_q == 5'd7) begin
                    hid_d[idx_q] = hid_val;
                    cnt_d        = 5'd0;
                    if (idx_q == 4'd15) begin
                        state_d = StL1Mac;
                        idx_d   = 4'd0;
                    end else begin
                        state_d = StL0Mac;
                        idx_d   = idx_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StL1Mac: begin
                if (cnt_q == 5'd0)       acc_d = '0;
                else if (cnt_q <= 5'd16) acc_d = acc_q + prod;
                if (cnt_q == 5'd17) begin
                    stg_d[idx_q[1:0]] = acc_q[23:8] + w_rdata;
                    cnt_d             = 5'd0;
                    if (idx_q[1:0] == 2'd3) begin
                        state_d = StArgmax;
                        idx_d   = 4'd0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StArgmax: begin
                out_d   = stg_q;
                stage_d = best;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Reads are registered, so they are derived from the next state.
        if (state_d == StL0Mac && cnt_d <= 5'd8) begin
            rd_en_d = 1'b1;
            addr_d  = (cnt_d == 5'd8) ? (8'd128 + {4'd0, idx_d})
                                      : {1'b0, idx_d, cnt_d[2:0]};
        end else if (state_d == StL1Mac && cnt_d <= 5'd16) begin
            rd_en_d = 1'b1;
            addr_d  = (cnt_d == 5'd16) ? (8'd208 + {6'd0, idx_d[1:0]})
                                       : (8'd144 + {2'd0, idx_d[1:0], cnt_d[3:0]});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            feat_q  <= '{default: '0};
            hid_q   <= '{default: '0};
            acc_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            stg_q   <= '{default: '0};
            out_q   <= '{default: '0};
            stage_q <= '0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            feat_q  <= feat_d;
            hid_q   <= hid_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            stg_q   <= stg_d;
            out_q   <= out_d;
            stage_q <= stage_d;
            done_q  <= done_d;
            rd_en_q <= rd_en_d;
            addr_q  <= addr_d;
        end
    end

    assign busy            = (state_q != StIdle);
    assign done            = done_q;
    assign w_rd_en         = rd_en_q;
    assign w_addr          = addr_q;
    assign o0              = out_q[0];
    assign o1              = out_q[1];
    assign o2              = out_q[2];
    assign o3              = out_q[3];
    assign predicted_stage = stage_q;

endmodule

// File: tb/tb_ann_seq_ctrl.sv
// Self-checking bench for ann_seq_ctrl: synchronous weight memory model,
// arithmetic reference model of the 8-16-4 network, scenario tasks.
module tb_ann_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] f [8];
    logic        w_rd_en;
    logic [7:0]  w_addr;
    logic [15:0] w_rdata = '0;
    logic        busy, done;
    logic [15:0] o0, o1, o2, o3;
    logic [1:0]  predicted_stage;
    logic [63:0] outs;

    logic [15:0] mem [256];
    bit          log_en = 1'b0;
    logic [7:0]  addr_log [$];

    int n_tests = 0;
    int n_fail  = 0;

    // Done is registered by edge E0+361, i.e. first seen when sampling at E0+362.
    localparam int DoneEdge  = 361;
    localparam int BusyCycles = 361;

    ann_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .f0(f[0]), .f1(f[1]), .f2(f[2]), .f3(f[3]),
        .f4(f[4]), .f5(f[5]), .f6(f[6]), .f7(f[7]),
        .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rdata(w_rdata),
        .busy(busy), .done(done),
        .o0(o0), .o1(o1), .o2(o2), .o3(o3),
        .predicted_stage(predicted_stage)
    );

    assign outs = {o0, o1, o2, o3};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (w_rd_en) begin
            w_rdata <= mem[w_addr];
            if (log_en) addr_log.push_back(w_addr);
        end
    end

    // Reference: plain integer arithmetic straight from the network definition.
    function automatic void ref_model(output logic [63:0] eo, output logic [1:0] es);
        int          acc;
        longint      a, mag;
        int          hid [16];
        logic [15:0] o16 [4];
        for (int i = 0; i < 16; i++) begin
            acc = 0;
            for (int j = 0; j < 8; j++)
                acc += int'($signed(f[j])) * int'($signed(mem[i*8+j]));
            acc += int'($signed(mem[128+i])) * 256;
            a   = longint'(acc);
            mag = (a < 0) ? -a : a;
            hid[i] = int'((a * 256) / (256 + mag));
        end
        for (int k = 0; k < 4; k++) begin
            acc = 0;
            for (int j = 0; j < 16; j++)
                acc += hid[j] * int'($signed(mem[144+k*16+j]));
            o16[k] = 16'((acc >>> 8) + int'($signed(mem[208+k])));
        end
        es = 2'd0;
        for (int k = 1; k < 4; k++)
            if ($signed(o16[k]) > $signed(o16[es])) es = 2'(k);
        eo = {o16[0], o16[1], o16[2], o16[3]};
    endfunction

    function automatic logic [15:0] rnd16(input int mode);
        int v;
        if (mode == 0)      v = int'($urandom);
        else if (mode == 1) v = int'($urandom_range(0, 1023)) - 512;
        else                v = int'($urandom_range(0, 127)) - 64;
        return 16'(v);
    endfunction

    task automatic fill_random(input int mode);
        for (int i = 0; i < 256; i++) mem[i] = rnd16(mode);
        for (int j = 0; j < 8; j++) f[j] = rnd16(mode);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    // Start is sampled at the second edge (E0); returns #1 after E0.
    task automatic launch();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // n = edges after E0 until done is seen (-1 on timeout); optional start pulse.
    task automatic wait_done(input int pulse_at, output int n, output int busy_cnt);
        n = 0;
        busy_cnt = 0;
        while (n < 2000 && done !== 1'b1) begin
            if (busy === 1'b1) busy_cnt++;
            @(posedge clk);
            #1;
            n++;
            start = (n == pulse_at - 1);
        end
        start = 1'b0;
        if (done !== 1'b1) n = -1;
    endtask

    task automatic test_reset();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_tests++; if (w_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", w_rd_en); end
        n_tests++; if (w_addr !== 8'd0) begin n_fail++; $display("FAIL reset_addr: got %h want 00", w_addr); end
        n_tests++; if (outs !== 64'd0) begin n_fail++; $display("FAIL reset_outs: got %h want 0", outs); end
        n_tests++; if (predicted_stage !== 2'd0) begin n_fail++; $display("FAIL reset_stage: got %0d want 0", predicted_stage); end
    endtask

    task automatic test_zero_weights();
        int n, bc;
        clear_mem();
        mem[208] = 16'd5; mem[209] = 16'hFFFD; mem[210] = 16'd9; mem[211] = 16'd9;
        for (int j = 0; j < 8; j++) f[j] = rnd16(0);
        launch();
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_accept: got %b want 1", busy); end
        wait_done(-1, n, bc);
        n_tests++; if (n !== DoneEdge) begin n_fail++; $display("FAIL latency: got %0d want %0d", n, DoneEdge); end
        n_tests++; if (bc !== BusyCycles) begin n_fail++; $display("FAIL busy_len: got %0d want %0d", bc, BusyCycles); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_at_done: got %b want 0", busy); end
        n_tests++; if (outs !== {16'd5, 16'hFFFD, 16'd9, 16'd9}) begin n_fail++; $display("FAIL zero_w_outs: got %h want 0005fffd00090009", outs); end
        n_tests++; if (predicted_stage !== 2'd2) begin n_fail++; $display("FAIL zero_w_stage: got %0d want 2", predicted_stage); end
        @(posedge clk); #1;
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: got %b want 0", done); end
    endtask

    task automatic test_single_hidden(input logic [15:0] w0, input logic [63:0] eo,
                                      input logic [1:0] es);
        int n, bc;
        clear_mem();
        for (int j = 0; j < 8; j++) f[j] = rnd16(0);
        f[0] = 16'h0100; mem[0] = w0; mem[144] = 16'h0100;
        launch();
        wait_done(-1, n, bc);
        n_tests++; if (n !== DoneEdge) begin n_fail++; $display("FAIL hid_latency: got %0d want %0d", n, DoneEdge); end
        n_tests++; if (outs !== eo) begin n_fail++; $display("FAIL hid_outs w0=%h: got %h want %h", w0, outs, eo); end
        n_tests++; if (predicted_stage !== es) begin n_fail++; $display("FAIL hid_stage w0=%h: got %0d want %0d", w0, predicted_stage, es); end
    endtask

    task automatic test_bus_order();
        int n, bc, sz;
        logic [63:0] eo;
        logic [1:0]  es;
        logic [7:0]  exp_first [9];
        fill_random(1);
        ref_model(eo, es);
        for (int j = 0; j < 8; j++) exp_first[j] = 8'(j);
        exp_first[8] = 8'd128;
        addr_log.delete();
        log_en = 1'b1;
        launch();
        wait_done(-1, n, bc);
        log_en = 1'b0;
        sz = addr_log.size();
        n_tests++; if (sz !== 212) begin n_fail++; $display("FAIL read_count: got %0d want 212", sz); end
        for (int j = 0; j < 9; j++) begin
            n_tests++;
            if (j < sz && addr_log[j] !== exp_first[j]) begin
                n_fail++; $display("FAIL read_addr[%0d]: got %0d want %0d", j, addr_log[j], exp_first[j]);
            end
        end
        n_tests++; if (sz == 0 || addr_log[sz-1] !== 8'd211) begin n_fail++; $display("FAIL last_read: got %0d want 211", sz ? addr_log[sz-1] : 8'd0); end
        n_tests++; if (outs !== eo) begin n_fail++; $display("FAIL bus_outs: got %h want %h", outs, eo); end
    endtask

    task automatic test_random();
        int n, bc;
        logic [63:0] eo;
        logic [1:0]  es;
        for (int it = 0; it < 9; it++) begin
            fill_random(it % 3);
            ref_model(eo, es);
            launch();
            for (int j = 0; j < 8; j++) f[j] = rnd16(0);  // features must be latched
            wait_done(-1, n, bc);
            n_tests++; if (n !== DoneEdge) begin n_fail++; $display("FAIL rnd_latency it%0d: got %0d want %0d", it, n, DoneEdge); end
            n_tests++; if (outs !== eo) begin n_fail++; $display("FAIL rnd_outs it%0d: got %h want %h", it, outs, eo); end
            n_tests++; if (predicted_stage !== es) begin n_fail++; $display("FAIL rnd_stage it%0d: got %0d want %0d", it, predicted_stage, es); end
        end
    endtask

    task automatic test_ignore_start();
        int n, bc;
        logic [63:0] eo;
        logic [1:0]  es;
        fill_random(2);
        ref_model(eo, es);
        launch();
        wait_done(50, n, bc);
        n_tests++; if (n !== DoneEdge) begin n_fail++; $display("FAIL ign_latency: got %0d want %0d", n, DoneEdge); end
        start = 1'b1;  // asserted in the done cycle
        @(posedge clk);
        #1 start = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_busy: got %b want 0", busy); end
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (busy !== 1'b0 || w_rd_en !== 1'b0) begin n_fail++; $display("FAIL ign_idle: got busy=%b rd=%b want 0 0", busy, w_rd_en); end
        n_tests++; if (outs !== eo) begin n_fail++; $display("FAIL ign_outs: got %h want %h", outs, eo); end
        n_tests++; if (predicted_stage !== es) begin n_fail++; $display("FAIL ign_stage: got %0d want %0d", predicted_stage, es); end
    endtask

    task automatic test_back_to_back();
        int n, bc;
        logic [63:0] eo;
        logic [1:0]  es;
        for (int it = 0; it < 2; it++) begin
            fill_random(1);
            ref_model(eo, es);
            launch();  // first start sampled on the edge after the done cycle
            wait_done(-1, n, bc);
            n_tests++; if (n !== DoneEdge) begin n_fail++; $display("FAIL b2b_latency it%0d: got %0d want %0d", it, n, DoneEdge); end
            n_tests++; if (outs !== eo || predicted_stage !== es) begin n_fail++; $display("FAIL b2b_result it%0d: got %h/%0d want %h/%0d", it, outs, predicted_stage, eo, es); end
        end
    endtask

    task automatic test_reset_mid();
        int n, bc;
        logic [63:0] eo;
        logic [1:0]  es;
        fill_random(1);
        launch();
        repeat (99) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        n_tests++; if (w_rd_en !== 1'b0 || w_addr !== 8'd0) begin n_fail++; $display("FAIL mid_rst_bus: got %b/%h want 0/00", w_rd_en, w_addr); end
        n_tests++; if (outs !== 64'd0 || predicted_stage !== 2'd0) begin n_fail++; $display("FAIL mid_rst_outs: got %h/%0d want 0/0", outs, predicted_stage); end
        rst = 1'b0;
        fill_random(2);
        ref_model(eo, es);
        launch();
        wait_done(-1, n, bc);
        n_tests++; if (n !== DoneEdge) begin n_fail++; $display("FAIL post_rst_latency: got %0d want %0d", n, DoneEdge); end
        n_tests++; if (outs !== eo || predicted_stage !== es) begin n_fail++; $display("FAIL post_rst_result: got %h/%0d want %h/%0d", outs, predicted_stage, eo, es); end
    endtask

    initial begin
        for (int j = 0; j < 8; j++) f[j] = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_zero_weights();
        test_single_hidden(16'h0100, {16'd255, 16'd0, 16'd0, 16'd0}, 2'd0);
        test_single_hidden(16'hFF00, {16'hFF01, 16'd0, 16'd0, 16'd0}, 2'd1);
        test_bus_order();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
